mlp_ctrl_pipe: RTL and testbench

Parametrised elastic pipeline buffer for the MLP controller's control bundle (done, neuron address, weight address, accumulator reset, output-neuron address, neuron write). It sits between the address-generation stage and the memory/MAC stages. It adds per-stage valid bits, downstream backpressure with bubble collapsing, a synchronous flush on `run` low, and an occupancy count. Latency is configurable via `DEPTH`.

---
 rtl/mlp_ctrl_pipe.sv | 95 +++++++++
 tb/tb_mlp_ctrl_pipe.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mlp_ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module   : mlp_ctrl_pipe
// Function : Elastic DEPTH-stage buffer for the MLP controller control bundle,
//            with bubble collapsing, synchronous flush on run=0 and occupancy.
// Revision : 1.0 - initial release
// ============================================================================
module mlp_ctrl_pipe #(
    parameter int DATA_W = 43,
    parameter int DEPTH  = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       run,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int OCC_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0]  r_v;
    logic [DATA_W-1:0] r_d [DEPTH];
    logic [OCC_W-1:0]  r_occ;

    logic [DEPTH-1:0]  w_acc;
    logic [DEPTH-1:0]  w_src_v;
    logic [DATA_W-1:0] w_src_d [DEPTH];
    logic              w_in_xfer;
    logic              w_out_xfer;

    generate
        for (genvar k = 0; k < DEPTH; k++) begin : g_stage
            // A stage may load when any stage from here to the output has a hole
            // or the sink drains; flattened form of the ripple accept chain.
            assign w_acc[k] = out_ready | ~(&r_v[DEPTH-1:k]);
            if (k == 0) begin : g_head
                assign w_src_v[k] = in_valid;
                assign w_src_d[k] = in_data;
            end else begin : g_body
                assign w_src_v[k] = r_v[k-1];
                assign w_src_d[k] = r_d[k-1];
            end
        end
    endgenerate

    assign in_ready   = run & w_acc[0];
    assign w_in_xfer  = in_valid & in_ready;
    assign w_out_xfer = r_v[DEPTH-1] & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_d[k] <= '0;
            end
        end else if (!run) begin
            r_v <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_d[k] <= '0;
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (w_acc[k]) begin
                    r_v[k] <= w_src_v[k];
                    if (w_src_v[k]) begin
                        r_d[k] <= w_src_d[k];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occ <= '0;
        end else if (!run) begin
            r_occ <= '0;
        end else if (w_in_xfer && !w_out_xfer) begin
            r_occ <= r_occ + OCC_W'(1);
        end else if (!w_in_xfer && w_out_xfer) begin
            r_occ <= r_occ - OCC_W'(1);
        end
    end

    assign out_valid = r_v[DEPTH-1];
    assign out_data  = r_d[DEPTH-1];
    assign occupancy = r_occ;

endmodule
`default_nettype wire

// File: tb/tb_mlp_ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_mlp_ctrl_pipe
// Function : Directed self-checking bench for mlp_ctrl_pipe at DEPTH=3 and 1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mlp_ctrl_pipe;

    localparam int DW = 43;

    logic          clk;
    logic          rst_n;
    logic          run;

    logic          a_in_valid;
    logic [DW-1:0] a_in_data;
    logic          a_in_ready;
    logic          a_out_valid;
    logic [DW-1:0] a_out_data;
    logic          a_out_ready;
    logic [1:0]    a_occ;

    logic          b_in_valid;
    logic [DW-1:0] b_in_data;
    logic          b_in_ready;
    logic          b_out_valid;
    logic [DW-1:0] b_out_data;
    logic          b_out_ready;
    logic [0:0]    b_occ;

    int n_checks;
    int n_errors;
    logic [DW-1:0] q[$];
    logic [DW-1:0] exp_d;

    mlp_ctrl_pipe #(.DATA_W(DW), .DEPTH(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .run(run),
        .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
        .out_valid(a_out_valid), .out_data(a_out_data), .out_ready(a_out_ready),
        .occupancy(a_occ)
    );

    mlp_ctrl_pipe #(.DATA_W(DW), .DEPTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .run(run),
        .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
        .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(b_out_ready),
        .occupancy(b_occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0; run = 1'b0;
        a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;

        // ---------------- reset state ----------------
        #2;
        chk("rst_inrdy_run0", 64'(a_in_ready), 64'(0));
        run = 1'b1;
        #1;
        chk("rst_inrdy_run1", 64'(a_in_ready), 64'(1));
        chk("rst_oval", 64'(a_out_valid), 64'(0));
        chk("rst_odata", 64'(a_out_data), 64'(0));
        chk("rst_occ", 64'(a_occ), 64'(0));
        chk("rst_occ_d1", 64'(b_occ), 64'(0));
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // ---------------- streaming, DEPTH=3 ----------------
        a_out_ready = 1'b1;
        for (int c = 0; c < 13; c++) begin
            a_in_valid = (c < 10);
            a_in_data  = DW'(c + 1);
            #1;
            if (c < 10) chk("str_inrdy", 64'(a_in_ready), 64'(1));
            tick();
            chk("str_oval", 64'(a_out_valid), 64'((c >= 2 && c <= 11) ? 1 : 0));
            if (c >= 2 && c <= 11) chk("str_odata", 64'(a_out_data), 64'(c - 1));
            chk("str_occ", 64'(a_occ), 64'(c <= 9 ? ((c + 1 > 3) ? 3 : c + 1) : 12 - c));
        end
        a_in_valid = 1'b0;

        // ---------------- backpressure / bubble collapse ----------------
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_data = DW'('h11);
        #1; chk("bp_rdy1", 64'(a_in_ready), 64'(1));
        tick();
        a_in_valid = 1'b0;
        tick();
        a_in_valid = 1'b1; a_in_data = DW'('h22);
        #1; chk("bp_rdy2", 64'(a_in_ready), 64'(1));
        tick();
        chk("bp_occ2", 64'(a_occ), 64'(2));
        a_in_data = DW'('h33);
        #1; chk("bp_rdy3", 64'(a_in_ready), 64'(1));
        tick();
        a_in_data = DW'('h44);
        #1;
        chk("bp_full_rdy", 64'(a_in_ready), 64'(0));
        chk("bp_full_occ", 64'(a_occ), 64'(3));
        tick();
        chk("bp_hold_occ", 64'(a_occ), 64'(3));
        chk("bp_hold_data", 64'(a_out_data), 64'('h11));
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        tick();
        chk("bp_rel_d2", 64'(a_out_data), 64'('h22));
        chk("bp_rel_occ", 64'(a_occ), 64'(2));
        tick();
        chk("bp_rel_d3", 64'(a_out_data), 64'('h33));
        tick();
        chk("bp_empty_v", 64'(a_out_valid), 64'(0));
        chk("bp_empty_occ", 64'(a_occ), 64'(0));

        // ---------------- full with simultaneous in/out ----------------
        a_out_ready = 1'b0;
        a_in_valid = 1'b1;
        for (int j = 0; j < 3; j++) begin
            a_in_data = DW'('h51 + j);
            tick();
        end
        chk("fu_occ", 64'(a_occ), 64'(3));
        a_out_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            a_in_data = DW'('h54 + j);
            #1;
            chk("fu_inrdy", 64'(a_in_ready), 64'(1));
            chk("fu_oval", 64'(a_out_valid), 64'(1));
            chk("fu_odata", 64'(a_out_data), 64'('h51 + j));
            tick();
            chk("fu_occ_run", 64'(a_occ), 64'(3));
        end
        a_in_valid = 1'b0;
        for (int j = 0; j < 3; j++) begin
            chk("fu_drain", 64'(a_out_data), 64'('h56 + j));
            tick();
        end
        chk("fu_drained", 64'(a_out_valid), 64'(0));

        // ---------------- flush ----------------
        a_in_valid = 1'b1;
        a_in_data = DW'('h61); tick();
        a_in_data = DW'('h62); tick();
        chk("fl_occ2", 64'(a_occ), 64'(2));
        run = 1'b0;
        a_in_data = DW'('h63);
        #1;
        chk("fl_inrdy", 64'(a_in_ready), 64'(0));
        tick();
        chk("fl_oval", 64'(a_out_valid), 64'(0));
        chk("fl_occ", 64'(a_occ), 64'(0));
        run = 1'b1;
        a_in_valid = 1'b0;
        for (int j = 0; j < 3; j++) begin
            tick();
            chk("fl_no_ghost", 64'(a_out_valid), 64'(0));
        end

        // ---------------- async reset mid-stream ----------------
        a_in_valid = 1'b1;
        for (int j = 0; j < 4; j++) begin
            a_in_data = DW'('h71 + j);
            tick();
        end
        chk("ar_pre_v", 64'(a_out_valid), 64'(1));
        chk("ar_pre_d", 64'(a_out_data), 64'('h72));
        a_in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_oval", 64'(a_out_valid), 64'(0));
        chk("ar_occ", 64'(a_occ), 64'(0));
        chk("ar_odata", 64'(a_out_data), 64'(0));
        chk("ar_inrdy", 64'(a_in_ready), 64'(1));
        tick();
        rst_n = 1'b1;
        for (int j = 0; j < 4; j++) begin
            tick();
            chk("ar_no_stale", 64'(a_out_valid), 64'(0));
        end

        // ---------------- DEPTH=1 directed ----------------
        b_out_ready = 1'b0;
        b_in_valid = 1'b1; b_in_data = DW'('hAA);
        tick();
        b_in_valid = 1'b0;
        #1;
        chk("d1_oval", 64'(b_out_valid), 64'(1));
        chk("d1_odata", 64'(b_out_data), 64'('hAA));
        chk("d1_full_rdy", 64'(b_in_ready), 64'(0));
        b_out_ready = 1'b1;
        #1;
        chk("d1_pass_rdy", 64'(b_in_ready), 64'(1));
        tick();
        chk("d1_empty", 64'(b_occ), 64'(0));

        // ---------------- DEPTH=1 random vs FIFO scoreboard ----------------
        for (int c = 0; c < 1000; c++) begin
            b_in_valid  = 1'($urandom_range(0, 1));
            b_out_ready = 1'($urandom_range(0, 1));
            b_in_data   = DW'({$urandom(), $urandom()});
            #1;
            chk("d1r_occ", 64'(b_occ), 64'(q.size()));
            if (b_out_valid && b_out_ready) begin
                if (q.size() == 0) begin
                    chk("d1r_underflow", 64'(1), 64'(0));
                end else begin
                    exp_d = q.pop_front();
                    chk("d1r_data", 64'(b_out_data), 64'(exp_d));
                end
            end
            if (b_in_valid && b_in_ready) q.push_back(b_in_data);
            tick();
        end
        b_in_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
